// File: rtl/camera_cfg_pkg.sv
// Shared types and constants for the camera register configuration sequencer.
// The state encoding, end-of-table marker and LUT entry field positions are defined here.
package camera_cfg_pkg;

  typedef enum logic [3:0] {
    PWRUP,
    FETCH,
    DECODE,
    REQ,
    WAIT,
    RETRY_GAP,
    SETTLE,
    NEXT,
    DONE,
    ERROR
  } cfg_state_t;

  localparam logic [7:0] END_MARKER = 8'hff;

  // Layout of one LUT entry: {dev_addr, reg_addr, data}
  localparam int DEV_MSB  = 31;
  localparam int DEV_LSB  = 24;
  localparam int REG_MSB  = 23;
  localparam int REG_LSB  = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cfg_delay_counter.sv
// Loadable down-counter with a zero flag. It holds at zero instead of wrapping.
// It comes out of reset already loaded, so a delay can start right after reset.
module cfg_delay_counter #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_en,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= RESET_VALUE;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_en && !o_zero) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/camera_config_sequencer.sv
// Walks the camera register LUT and issues one I2C write per entry.
// It handles the power-up delay, the settle time after the index-0 write, NACK retries and end of table.
module camera_config_sequencer #(
  parameter int         POWERUP_DELAY = 1000000,
  parameter int         SETTLE_DELAY  = 100000,
  parameter int         MAX_RETRIES   = 3,
  parameter logic [7:0] END_MARKER    = camera_cfg_pkg::END_MARKER,
  parameter int         MAX_INDEX     = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_restart,
  output logic [9:0]  o_lut_index,
  input  logic [31:0] i_lut_data,
  input  logic        i_lut_addr_2byte,
  output logic        o_i2c_req,
  output logic [7:0]  o_i2c_dev_addr,
  output logic [15:0] o_i2c_reg_addr,
  output logic        o_i2c_addr_2byte,
  output logic [7:0]  o_i2c_wdata,
  input  logic        i_i2c_done,
  input  logic        i_i2c_nack,
  output logic        o_busy,
  output logic        o_config_done,
  output logic        o_config_error,
  output logic [9:0]  o_entry_count
);

  import camera_cfg_pkg::*;

  // Delays are loaded as N-1 so each delay state lasts exactly N cycles (N >= 1).
  localparam int               MAX_DELAY   = max_int(POWERUP_DELAY, SETTLE_DELAY);
  localparam int               CNT_W       = $clog2(MAX_DELAY + 1);
  localparam int               ATT_W       = $clog2(MAX_RETRIES + 2);
  localparam logic [CNT_W-1:0] PWRUP_LOAD  = CNT_W'(POWERUP_DELAY - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_DELAY - 1);
  localparam logic [ATT_W-1:0] ATT_LIMIT   = ATT_W'(MAX_RETRIES);
  localparam logic [9:0]       LAST_INDEX  = 10'(MAX_INDEX);

  cfg_state_t       r_state;
  cfg_state_t       w_nextState;
  logic [9:0]       r_lutIndex;
  logic [9:0]       r_entryCount;
  logic [ATT_W-1:0] r_attempt;
  logic [7:0]       r_devAddr;
  logic [15:0]      r_regAddr;
  logic             r_addr2byte;
  logic [7:0]       r_wdata;

  logic w_cntZero;
  logic w_cntLoad;
  logic w_cntEn;
  logic w_isMarker;
  logic w_ackDone;
  logic w_nackDone;
  logic w_canRetry;
  logic w_atLastIndex;
  logic w_restartOk;

  assign w_isMarker    = (i_lut_data[DEV_MSB:DEV_LSB] == END_MARKER);
  assign w_ackDone     = (r_state == WAIT) && i_i2c_done && !i_i2c_nack;
  assign w_nackDone    = (r_state == WAIT) && i_i2c_done && i_i2c_nack;
  assign w_canRetry    = (r_attempt < ATT_LIMIT);
  assign w_atLastIndex = (r_lutIndex == LAST_INDEX);
  assign w_restartOk   = i_restart && ((r_state == DONE) || (r_state == ERROR));
  assign w_cntLoad     = w_ackDone && (r_lutIndex == '0);
  assign w_cntEn       = (r_state == PWRUP) || (r_state == SETTLE);

  cfg_delay_counter #(
    .WIDTH       (CNT_W),
    .RESET_VALUE (PWRUP_LOAD)
  ) u_delay (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (w_cntLoad),
    .i_load_value (SETTLE_LOAD),
    .i_en         (w_cntEn),
    .o_zero       (w_cntZero)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= PWRUP;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      PWRUP:     if (w_cntZero) w_nextState = FETCH;
      FETCH:     w_nextState = DECODE;
      DECODE:    w_nextState = w_isMarker ? DONE : REQ;
      REQ:       w_nextState = WAIT;
      WAIT: begin
        if (w_ackDone) begin
          w_nextState = (r_lutIndex == '0) ? SETTLE : NEXT;
        end else if (w_nackDone) begin
          w_nextState = w_canRetry ? RETRY_GAP : ERROR;
        end
      end
      RETRY_GAP: w_nextState = REQ;
      SETTLE:    if (w_cntZero) w_nextState = NEXT;
      NEXT:      w_nextState = w_atLastIndex ? DONE : FETCH;
      DONE:      if (w_restartOk) w_nextState = FETCH;
      ERROR:     if (w_restartOk) w_nextState = FETCH;
      default:   w_nextState = PWRUP;
    endcase
  end

  // Request and status flags decode straight from the state register, so reset clears them asynchronously.
  always_comb begin
    o_i2c_req      = 1'b0;
    o_busy         = 1'b1;
    o_config_done  = 1'b0;
    o_config_error = 1'b0;
    case (r_state)
      REQ, WAIT: o_i2c_req = 1'b1;
      DONE: begin
        o_busy        = 1'b0;
        o_config_done = 1'b1;
      end
      ERROR: begin
        o_busy         = 1'b0;
        o_config_error = 1'b1;
      end
      default: o_i2c_req = 1'b0;
    endcase
  end

  // The I2C fields are only loaded in DECODE, so they stay stable across REQ, WAIT and retries.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lutIndex   <= '0;
      r_entryCount <= '0;
      r_attempt    <= '0;
      r_devAddr    <= '0;
      r_regAddr    <= '0;
      r_addr2byte  <= 1'b0;
      r_wdata      <= '0;
    end else begin
      if (r_state == DECODE) begin
        r_devAddr   <= i_lut_data[DEV_MSB:DEV_LSB];
        r_regAddr   <= i_lut_data[REG_MSB:REG_LSB];
        r_wdata     <= i_lut_data[DATA_MSB:DATA_LSB];
        r_addr2byte <= i_lut_addr_2byte;
        r_attempt   <= '0;
      end
      if (w_ackDone) begin
        r_entryCount <= r_entryCount + 1'b1;
      end
      if (w_nackDone && w_canRetry) begin
        r_attempt <= r_attempt + 1'b1;
      end
      if ((r_state == NEXT) && !w_atLastIndex) begin
        r_lutIndex <= r_lutIndex + 1'b1;
      end
      if (w_restartOk) begin
        r_lutIndex   <= '0;
        r_entryCount <= '0;
      end
    end
  end

  assign o_lut_index      = r_lutIndex;
  assign o_entry_count    = r_entryCount;
  assign o_i2c_dev_addr   = r_devAddr;
  assign o_i2c_reg_addr   = r_regAddr;
  assign o_i2c_addr_2byte = r_addr2byte;
  assign o_i2c_wdata      = r_wdata;

endmodule
